// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// It holds one transaction at a time: accept, wait LATENCY cycles, return the result tagged with the requester ID.
module alu_rr_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OPW     = 3,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero,
  output logic             busy
);

  // The counter holds values 1..15, so LATENCY must stay in that range.
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            last_grant;
  logic            sel;
  logic            any_valid;

  // When both requesters are valid, the one that was not granted last time wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign any_valid  = req0_valid | req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_op     <= sel ? req1_op : req0_op;
            alu_a      <= sel ? req1_a  : req0_a;
            alu_b      <= sel ? req1_b  : req0_b;
            last_grant <= sel;
            rsp_id     <= sel;
            cnt        <= CNTW'(LATENCY);
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            rsp_data  <= alu_res;
            rsp_zero  <= (alu_res == '0);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // rsp_data is kept after the handshake; only the ALU operands are cleared.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
